// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: picks the fetch PC source (PC+4, decode target, ALU target
// or hold), registers the redirect target, flushes the wrong-path pipeline
// registers, and counts the redirects it applies.
//
// Request protocol: dec_jump_in and ex_branch_in & ex_taken_in are
// single-cycle strobes with no ready/backpressure. A strobe sampled at a rising
// edge while the controller is IDLE is accepted. A strobe sampled while a
// redirect is pending (REDIR) is dropped, because it comes from a wrong-path
// instruction that this redirect flushes.
module pc_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             dec_jump_in,
  input  logic [XLEN-1:0]  dec_target_in,
  input  logic             ex_branch_in,
  input  logic             ex_taken_in,
  input  logic [XLEN-1:0]  ex_target_in,
  output logic [1:0]       pc_s_out,
  output logic [XLEN-1:0]  pc_dec_out,
  output logic [XLEN-1:0]  pc_alu_out,
  output logic             flush_ifid_out,
  output logic             flush_idex_out,
  output logic             flush_exmem_out,
  output logic             misalign_out,
  output logic [CNT_W-1:0] redirect_cnt_out,
  output logic [1:0]       dbg_state_out
);

  // Fetch select encodings.
  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_DEC  = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             src_q, src_d;       // 0 = decode target, 1 = ALU target
  logic [XLEN-1:0]  pc_dec_q;
  logic [XLEN-1:0]  pc_alu_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_req;
  logic             cap_dec;
  logic             cap_ex;
  logic             cnt_inc;

  assign ex_req = ex_branch_in & ex_taken_in;

  // Next state, capture strobes and outputs; outputs use only registered state
  // and stall_in, so request inputs never reach the outputs in the same cycle.
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    cap_dec         = 1'b0;
    cap_ex          = 1'b0;
    cnt_inc         = 1'b0;
    pc_s_out        = SEL_PC4;
    flush_ifid_out  = 1'b0;
    flush_idex_out  = 1'b0;
    flush_exmem_out = 1'b0;
    misalign_out    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_s_out = stall_in ? SEL_HOLD : SEL_PC4;
        // Execute holds the older instruction, so it wins over decode.
        if (ex_req) begin
          cap_ex  = 1'b1;
          src_d   = 1'b1;
          state_d = ST_REDIR;
        end else if (dec_jump_in) begin
          cap_dec = 1'b1;
          src_d   = 1'b0;
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (stall_in) begin
          // Defer: fetch holds, nothing is flushed, everything is kept.
          pc_s_out = SEL_HOLD;
        end else begin
          pc_s_out        = src_q ? SEL_ALU : SEL_DEC;
          flush_ifid_out  = 1'b1;
          flush_idex_out  = 1'b1;
          flush_exmem_out = src_q;
          misalign_out    = src_q ? pc_alu_q[1] : pc_dec_q[1];
          cnt_inc         = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and source registers; reset also drops a pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  // Target registers, loaded only when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_dec_q <= '0;
      pc_alu_q <= '0;
    end else begin
      if (cap_dec) begin
        pc_dec_q <= dec_target_in;
      end
      if (cap_ex) begin
        // JALR semantics: bit 0 of the computed target is cleared.
        pc_alu_q <= {ex_target_in[XLEN-1:1], 1'b0};
      end
    end
  end

  // Applied-redirect counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc_dec_out       = pc_dec_q;
  assign pc_alu_out       = pc_alu_q;
  assign redirect_cnt_out = cnt_q;
  assign dbg_state_out    = {src_q, state_q == ST_REDIR};

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vectors with hand-computed expectations.
// Non-idle output cycles (select != PC+4, or any flush) are matched against a
// queue of expected observations by a separate monitor.
module tb_pc_redirect_ctrl;

  localparam int XLEN = 32;
  localparam int CNT_W = 16;
  localparam int W = 2 + 3 + 1 + XLEN + XLEN + CNT_W;

  logic             clk;
  logic             rst;
  logic             stall_in;
  logic             dec_jump_in;
  logic [XLEN-1:0]  dec_target_in;
  logic             ex_branch_in;
  logic             ex_taken_in;
  logic [XLEN-1:0]  ex_target_in;

  logic [1:0]       pc_s_out, pc_s_s;
  logic [XLEN-1:0]  pc_dec_out, pc_dec_s;
  logic [XLEN-1:0]  pc_alu_out, pc_alu_s;
  logic             flush_ifid_out, flush_idex_out, flush_exmem_out, misalign_out;
  logic             flush_ifid_s, flush_idex_s, flush_exmem_s, misalign_s;
  logic [CNT_W-1:0] redirect_cnt_out;
  logic [1:0]       redirect_cnt_s;
  logic [1:0]       dbg_state_out, dbg_state_s;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  pc_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .dec_jump_in(dec_jump_in), .dec_target_in(dec_target_in),
    .ex_branch_in(ex_branch_in), .ex_taken_in(ex_taken_in), .ex_target_in(ex_target_in),
    .pc_s_out(pc_s_out), .pc_dec_out(pc_dec_out), .pc_alu_out(pc_alu_out),
    .flush_ifid_out(flush_ifid_out), .flush_idex_out(flush_idex_out),
    .flush_exmem_out(flush_exmem_out), .misalign_out(misalign_out),
    .redirect_cnt_out(redirect_cnt_out), .dbg_state_out(dbg_state_out)
  );

  // Second instance with a 2-bit counter, driven in parallel, for saturation.
  pc_redirect_ctrl #(.XLEN(XLEN), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .dec_jump_in(dec_jump_in), .dec_target_in(dec_target_in),
    .ex_branch_in(ex_branch_in), .ex_taken_in(ex_taken_in), .ex_target_in(ex_target_in),
    .pc_s_out(pc_s_s), .pc_dec_out(pc_dec_s), .pc_alu_out(pc_alu_s),
    .flush_ifid_out(flush_ifid_s), .flush_idex_out(flush_idex_s),
    .flush_exmem_out(flush_exmem_s), .misalign_out(misalign_s),
    .redirect_cnt_out(redirect_cnt_s), .dbg_state_out(dbg_state_s)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] obs(input logic [1:0] s, input logic fi, input logic fd,
                                       input logic fe, input logic m, input logic [XLEN-1:0] pd,
                                       input logic [XLEN-1:0] pa, input logic [CNT_W-1:0] c);
    return {s, fi, fd, fe, m, pd, pa, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_in      = 1'b0;
    dec_jump_in   = 1'b0;
    dec_target_in = '0;
    ex_branch_in  = 1'b0;
    ex_taken_in   = 1'b0;
    ex_target_in  = '0;
  endtask

  task automatic check_idle(input string name, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    check({name, "_pc_s"}, 32'(pc_s_out), 32'h0);
    check({name, "_cnt"}, 32'(redirect_cnt_out), 32'(cnt));
  endtask

  // Monitor: every non-idle output cycle must match the next expectation.
  always @(negedge clk) begin
    if (pc_s_out != 2'b00 || flush_ifid_out || flush_idex_out || flush_exmem_out || misalign_out) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = obs(pc_s_out, flush_ifid_out, flush_idex_out, flush_exmem_out, misalign_out,
                pc_dec_out, pc_alu_out, redirect_cnt_out);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL output_event: got 0x%0h expected 0x%0h", act, exp);
        end
      end
    end
  end

  // Stimulus.
  logic [1:0] sat_cnt[5];
  initial begin
    sat_cnt[0] = 2'd1; sat_cnt[1] = 2'd2; sat_cnt[2] = 2'd3; sat_cnt[3] = 2'd3; sat_cnt[4] = 2'd3;
    rst = 1'b0;
    clear_inputs();

    // Reset values.
    @(negedge clk);
    check("rst_pc_s", 32'(pc_s_out), 32'h0);
    check("rst_pc_dec", pc_dec_out, 32'h0);
    check("rst_pc_alu", pc_alu_out, 32'h0);
    check("rst_flush", {29'h0, flush_ifid_out, flush_idex_out, flush_exmem_out}, 32'h0);
    check("rst_misalign", 32'(misalign_out), 32'h0);
    check("rst_cnt", 32'(redirect_cnt_out), 32'h0);
    check("rst_dbg", 32'(dbg_state_out), 32'h0);
    tick();
    rst = 1'b1;

    // Ten quiet cycles.
    for (int i = 0; i < 10; i++) begin
      check_idle("quiet", 16'd0);
    end
    check("quiet_pc_dec", pc_dec_out, 32'h0);
    check("quiet_pc_alu", pc_alu_out, 32'h0);

    // One-cycle stall pulse in IDLE.
    tick();
    stall_in = 1'b1;
    exp_q.push_back(obs(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0));
    tick();
    stall_in = 1'b0;
    check_idle("stall_pulse_after", 16'd0);

    // Decode jump to 0x100.
    tick();
    dec_jump_in = 1'b1;
    dec_target_in = 32'h100;
    exp_q.push_back(obs(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 16'd0));
    tick();
    clear_inputs();
    tick();
    check_idle("dec_after", 16'd1);
    check("dec_pc_dec", pc_dec_out, 32'h100);

    // Execute and decode together: execute wins, bit 0 cleared, misaligned.
    tick();
    ex_branch_in = 1'b1;
    ex_taken_in = 1'b1;
    ex_target_in = 32'h203;
    dec_jump_in = 1'b1;
    dec_target_in = 32'h400;
    exp_q.push_back(obs(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h202, 16'd1));
    tick();
    clear_inputs();
    tick();
    check_idle("both_after", 16'd2);
    check("both_pc_dec_kept", pc_dec_out, 32'h100);
    check("both_pc_alu", pc_alu_out, 32'h202);
    tick();
    check_idle("both_no_second", 16'd2);

    // Execute redirect to 0x80 stalled for three cycles; decode jump ignored.
    tick();
    ex_branch_in = 1'b1;
    ex_taken_in = 1'b1;
    ex_target_in = 32'h80;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(obs(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 16'd2));
    end
    exp_q.push_back(obs(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 16'd2));
    tick();
    clear_inputs();
    stall_in = 1'b1;
    tick();
    dec_jump_in = 1'b1;
    dec_target_in = 32'h500;
    tick();
    dec_jump_in = 1'b0;
    dec_target_in = '0;
    tick();
    stall_in = 1'b0;
    tick();
    check_idle("stall_after", 16'd3);
    check("stall_pc_dec_kept", pc_dec_out, 32'h100);
    tick();
    check_idle("stall_no_extra", 16'd3);

    // Reset asserted during the REDIR cycle of a decode jump.
    tick();
    dec_jump_in = 1'b1;
    dec_target_in = 32'h600;
    tick();
    clear_inputs();
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pc_s", 32'(pc_s_out), 32'h0);
    check("midrst_flush", {29'h0, flush_ifid_out, flush_idex_out, flush_exmem_out}, 32'h0);
    check("midrst_cnt", 32'(redirect_cnt_out), 32'h0);
    check("midrst_pc_dec", pc_dec_out, 32'h0);
    tick();
    rst = 1'b1;
    check_idle("midrst_release", 16'd0);

    // Five back-to-back decode jumps; the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      tick();
      dec_jump_in = 1'b1;
      dec_target_in = 32'h1000 + 32'(i) * 32'h10;
      exp_q.push_back(obs(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i) * 32'h10, 32'h0, 16'(i)));
      @(negedge clk);
      if (i > 0) check($sformatf("sat_cnt_%0d", i - 1), 32'(redirect_cnt_s), 32'(sat_cnt[i - 1]));
      tick();
      clear_inputs();
    end
    tick();
    @(negedge clk);
    check("sat_cnt_4", 32'(redirect_cnt_s), 32'(sat_cnt[4]));
    check("sat_wide_cnt", 32'(redirect_cnt_out), 32'd5);

    // Drain and report.
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
